// File: rtl/instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_buffer
//
// Decouples the IF stage from instruction memory. A small bus FSM keeps at
// most one read outstanding, and returned words are queued with their PC in
// a DEPTH-entry FIFO. A branch redirect (pc_src) flushes the FIFO, restarts
// fetching at the target, and marks any in-flight response for discard.
//
// Parameters
//   DEPTH     FIFO entries, power of two, 2..16.
//   RESET_PC  First fetch address after reset.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   imem_req     out  request valid (held until imem_gnt)
//   imem_addr    out  word-aligned request address
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   read data valid
//   imem_rdata   in   instruction word
//   pc_src       in   redirect / flush
//   pc_branch    in   redirect target (low two bits ignored)
//   fetch_ready  in   IF stage consumes the head entry
//   fetch_valid  out  head entry valid
//   fetch_inst   out  head instruction, NOP (addi x0,x0,0) when not valid
//   fetch_pc     out  head PC, zero when not valid
//
// Build option
//   PREFETCH_BYPASS_EN  When defined, a response arriving into an empty FIFO
//                       is presented on the fetch outputs in the same cycle,
//                       and is not queued if the IF stage takes it at once.
//                       Undefined (default): fetch outputs come only from
//                       registered FIFO state, one cycle after rvalid.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module instruction_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_src,
  input  logic [31:0] pc_branch,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc
);

  localparam int unsigned     AW        = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]     CNT_ZERO  = (AW + 1)'(0);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [AW-1:0]   PTR_ZERO  = AW'(0);
  localparam logic [31:0]     NOP_INST  = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("instruction_prefetch_buffer: DEPTH must be a power of two in 2..16");
  end

  // Bus FSM state
  logic [1:0]  state_q,      state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;   // next address to request
  logic [31:0] req_addr_q,   req_addr_d;     // address of the outstanding request
  logic        drop_q,       drop_d;         // outstanding response is stale

  // FIFO state
  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] pc_mem_d   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] inst_mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic [31:0] seq_addr_s;
  logic        seq_drop_s;
  logic        rsp_accept_s;
  logic        push_s;
  logic        pop_s;
  logic        fifo_valid_s;
  logic        unused_branch_lsbs;

  assign unused_branch_lsbs = ^pc_branch[1:0];
  assign fifo_valid_s       = (count_q != CNT_ZERO);
  assign pop_s              = fifo_valid_s & fetch_ready & ~pc_src;

  // Bus FSM next state; redirect overrides the sequential address and drop flag
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    seq_addr_s   = fetch_addr_q;
    seq_drop_s   = drop_q;
    rsp_accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // No outstanding request here, so count alone bounds the reservation.
        if (!pc_src && (count_q < DEPTH_CNT)) begin
          state_d    = ST_REQ;
          req_addr_d = fetch_addr_q;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_gnt) begin
          state_d = ST_WAIT;
          // A doomed request must not advance the (already redirected) stream.
          if (!drop_q && !pc_src) begin
            seq_addr_s = req_addr_q + 32'd4;
          end else begin
            seq_addr_s = fetch_addr_q;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d      = ST_IDLE;
          seq_drop_s   = 1'b0;
          rsp_accept_s = !drop_q && !pc_src;
        end else begin
          state_d      = ST_WAIT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        seq_drop_s = 1'b0;
      end
    endcase

    if (pc_src) begin
      fetch_addr_d = {pc_branch[31:2], 2'b00};
      // Only a response still to come needs discarding; one arriving now is
      // already ignored through rsp_accept_s.
      drop_d       = (state_q == ST_REQ) || ((state_q == ST_WAIT) && !imem_rvalid);
    end else begin
      fetch_addr_d = seq_addr_s;
      drop_d       = seq_drop_s;
    end
  end

`ifdef PREFETCH_BYPASS_EN
  logic bypass_hit_s;
  logic bypass_take_s;

  assign bypass_hit_s  = rsp_accept_s & (count_q == CNT_ZERO);
  assign bypass_take_s = bypass_hit_s & fetch_ready;
  assign push_s        = rsp_accept_s & ~bypass_take_s;

  // Head outputs: FIFO head, else a response forwarded straight from the bus
  always_comb begin
    if (fifo_valid_s) begin
      fetch_valid = 1'b1;
      fetch_inst  = inst_mem_q[rd_ptr_q];
      fetch_pc    = pc_mem_q[rd_ptr_q];
    end else if (bypass_hit_s) begin
      fetch_valid = 1'b1;
      fetch_inst  = imem_rdata;
      fetch_pc    = req_addr_q;
    end else begin
      fetch_valid = 1'b0;
      fetch_inst  = NOP_INST;
      fetch_pc    = 32'd0;
    end
  end
`else
  assign push_s = rsp_accept_s;

  // Head outputs from registered FIFO state only
  always_comb begin
    if (fifo_valid_s) begin
      fetch_valid = 1'b1;
      fetch_inst  = inst_mem_q[rd_ptr_q];
      fetch_pc    = pc_mem_q[rd_ptr_q];
    end else begin
      fetch_valid = 1'b0;
      fetch_inst  = NOP_INST;
      fetch_pc    = 32'd0;
    end
  end
`endif

  // FIFO storage next state: write the accepted response at the tail
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (push_s) begin
      pc_mem_d[wr_ptr_q]   = req_addr_q;
      inst_mem_d[wr_ptr_q] = imem_rdata;
    end else begin
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pc_src) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Bus-side outputs come straight from flops
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = (state_q == ST_IDLE) ? fetch_addr_q : req_addr_q;

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= RESET_PC;
      req_addr_q   <= RESET_PC;
      drop_q       <= 1'b0;
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      count_q      <= CNT_ZERO;
      pc_mem_q     <= '{default: 32'd0};
      inst_mem_q   <= '{default: 32'd0};
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pc_mem_q     <= pc_mem_d;
      inst_mem_q   <= inst_mem_d;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// Directed, table-driven bench for instruction_prefetch_buffer (DEPTH=4,
// RESET_PC=0). Each record gives the inputs for one cycle and the outputs
// expected in that cycle; inputs change on the falling edge and outputs are
// sampled 1 ns later. Expectations follow PREFETCH_BYPASS_EN when defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_instruction_prefetch_buffer;

`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0010_0093;
  localparam logic [31:0] I1  = 32'h0020_0113;
  localparam logic [31:0] I2  = 32'h0030_0193;
  localparam logic [31:0] I3  = 32'h0040_0213;
  localparam logic [31:0] I4  = 32'h0050_0293;
  localparam logic [31:0] I5  = 32'h0060_0313;
  localparam logic [31:0] I6  = 32'h0070_0393;
  localparam logic [31:0] I7  = 32'hDEAD_0013;
  localparam logic [31:0] I8  = 32'h0080_0413;
  localparam logic [31:0] I9  = 32'hBAD0_0013;
  localparam logic [31:0] IB  = 32'h0050_0093;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        ps;
    logic [31:0] pb;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [42];

  instruction_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_src      (pc_src),
    .pc_branch   (pc_branch),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_pc    (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic ps,
                              input logic [31:0] pb, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_inst,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.ps = ps; v.pb = pb;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input int id, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %h, expected %h", id, what, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    reset       = v.rst;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    pc_src      = v.ps;
    pc_branch   = v.pb;
    fetch_ready = v.rdy;
    #1;
    check(id, "imem_req",    {31'd0, imem_req},    {31'd0, v.e_req});
    check(id, "imem_addr",   imem_addr,            v.e_addr);
    check(id, "fetch_valid", {31'd0, fetch_valid}, {31'd0, v.e_valid});
    check(id, "fetch_inst",  fetch_inst,           v.e_inst);
    check(id, "fetch_pc",    fetch_pc,             v.e_pc);
  endtask

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    pc_src = 1'b0; pc_branch = 32'd0; fetch_ready = 1'b0;

    //              rst   gnt   rv    rdata  ps    pb           rdy   req   addr         valid inst                pc
    // Reset, then streaming fetch with fetch_ready=1: PCs 0,4,8 every 3 cycles
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h0,       1'b0, NOP, 32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h0,       1'b0, NOP, 32'h0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b1, 32'h0,       1'b0, NOP, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, I0,    1'b0, 32'd0,       1'b1, 1'b0, 32'h0,       BYP,  BYP ? I0 : NOP, 32'h0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h4,       !BYP, !BYP ? I0 : NOP, 32'h0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b1, 32'h4,       1'b0, NOP, 32'h0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, I1,    1'b0, 32'd0,       1'b1, 1'b0, 32'h4,       BYP,  BYP ? I1 : NOP, BYP ? 32'h4 : 32'h0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h8,       !BYP, !BYP ? I1 : NOP, !BYP ? 32'h4 : 32'h0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b1, 32'h8,       1'b0, NOP, 32'h0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, I2,    1'b0, 32'd0,       1'b0, 1'b0, 32'h8,       BYP,  BYP ? I2 : NOP, BYP ? 32'h8 : 32'h0);
    // fetch_ready=0: fill to four entries, then no more requests
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b0, 32'hC,       1'b1, I2, 32'h8);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b1, 32'hC,       1'b1, I2, 32'h8);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, I3,    1'b0, 32'd0,       1'b0, 1'b0, 32'hC,       1'b1, I2, 32'h8);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b0, 32'h10,      1'b1, I2, 32'h8);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b1, 32'h10,      1'b1, I2, 32'h8);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, I4,    1'b0, 32'd0,       1'b0, 1'b0, 32'h10,      1'b1, I2, 32'h8);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b0, 32'h14,      1'b1, I2, 32'h8);
    tbl[17] = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b1, 32'h14,      1'b1, I2, 32'h8);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, I5,    1'b0, 32'd0,       1'b0, 1'b0, 32'h14,      1'b1, I2, 32'h8);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b0, 32'h18,      1'b1, I2, 32'h8);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b0, 32'h18,      1'b1, I2, 32'h8);
    // Drain in order; request resumes once a slot frees; stall holds the head
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h18,      1'b1, I2, 32'h8);
    tbl[22] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h18,      1'b1, I3, 32'hC);
    tbl[23] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b1, 32'h18,      1'b1, I4, 32'h10);
    tbl[24] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b1, 32'h18,      1'b1, I5, 32'h14);
    tbl[25] = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b1, 32'h18,      1'b1, I5, 32'h14);
    // Push and pop together keep the count
    tbl[26] = mk(1'b0, 1'b0, 1'b1, I6,    1'b0, 32'd0,       1'b1, 1'b0, 32'h18,      1'b1, I5, 32'h14);
    tbl[27] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b0, 32'h1C,      1'b1, I6, 32'h18);
    tbl[28] = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b1, 32'h1C,      1'b1, I6, 32'h18);
    // Redirect to 0x103 while in WAIT: flush, stale response dropped, refetch 0x100
    tbl[29] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h103,     1'b0, 1'b0, 32'h1C,      1'b1, I6, 32'h18);
    tbl[30] = mk(1'b0, 1'b0, 1'b1, I7,    1'b0, 32'd0,       1'b0, 1'b0, 32'h1C,      1'b0, NOP, 32'h0);
    tbl[31] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h100,     1'b0, NOP, 32'h0);
    tbl[32] = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b1, 32'h100,     1'b0, NOP, 32'h0);
    tbl[33] = mk(1'b0, 1'b0, 1'b1, I8,    1'b0, 32'd0,       1'b1, 1'b0, 32'h100,     BYP,  BYP ? I8 : NOP, BYP ? 32'h100 : 32'h0);
    tbl[34] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b0, 32'h104,     !BYP, !BYP ? I8 : NOP, !BYP ? 32'h100 : 32'h0);
    tbl[35] = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,       1'b0, 1'b1, 32'h104,     !BYP, !BYP ? I8 : NOP, !BYP ? 32'h100 : 32'h0);
    // Redirect together with rvalid and a pop: response dropped, FIFO empty
    tbl[36] = mk(1'b0, 1'b0, 1'b1, I9,    1'b1, 32'h200,     1'b1, 1'b0, 32'h104,     !BYP, !BYP ? I8 : NOP, !BYP ? 32'h100 : 32'h0);
    tbl[37] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h200,     1'b0, NOP, 32'h0);
    tbl[38] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b1, 32'h200,     1'b0, NOP, 32'h0);
    // Reset in REQ: request drops at once; rvalid just after release ignored
    tbl[39] = mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b0, 32'h0,       1'b0, NOP, 32'h0);
    tbl[40] = mk(1'b0, 1'b0, 1'b1, I9,    1'b0, 32'd0,       1'b1, 1'b0, 32'h0,       1'b0, NOP, 32'h0);
    tbl[41] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,       1'b1, 1'b1, 32'h0,       1'b0, NOP, 32'h0);

    for (int i = 0; i < 42; i++) begin
      apply(tbl[i], i);
    end

    // Sequence: redirect to 0x8 coinciding with rvalid (no drop), then
    // rvalid at 0x8 into an empty FIFO: same cycle with bypass, next otherwise.
    apply(mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0,  1'b0, NOP, 32'h0), 100);
    apply(mk(1'b0, 1'b0, 1'b1, I9,    1'b1, 32'h8, 1'b1, 1'b0, 32'h0,  1'b0, NOP, 32'h0), 101);
    apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h8,  1'b0, NOP, 32'h0), 102);
    apply(mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8,  1'b0, NOP, 32'h0), 103);
    apply(mk(1'b0, 1'b0, 1'b1, IB,    1'b0, 32'd0, 1'b1, 1'b0, 32'h8,
             BYP, BYP ? IB : NOP, BYP ? 32'h8 : 32'h0), 104);
    apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'hC,
             !BYP, !BYP ? IB : NOP, !BYP ? 32'h8 : 32'h0), 105);

    // Sequence: redirect while in REQ before gnt. Address stays stable, the
    // late response is discarded, and fetching resumes at the target 0x40.
    apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1, 1'b1, 32'hC,  1'b0, NOP, 32'h0), 110);
    apply(mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 1'b1, 32'hC,  1'b0, NOP, 32'h0), 111);
    apply(mk(1'b0, 1'b0, 1'b1, I7,    1'b0, 32'd0,  1'b1, 1'b0, 32'hC,  1'b0, NOP, 32'h0), 112);
    apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 1'b0, 32'h40, 1'b0, NOP, 32'h0), 113);
    apply(mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 1'b1, 32'h40, 1'b0, NOP, 32'h0), 114);
    apply(mk(1'b0, 1'b0, 1'b1, I1,    1'b0, 32'd0,  1'b1, 1'b0, 32'h40,
             BYP, BYP ? I1 : NOP, BYP ? 32'h40 : 32'h0), 115);
    apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 1'b0, 32'h44,
             !BYP, !BYP ? I1 : NOP, !BYP ? 32'h40 : 32'h0), 116);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
